// File: rtl/signed_comparator.sv
// -----------------------------------------------------------------------------
// signed_comparator
//
// Purpose:
//   Registered two's-complement magnitude comparator. On every rising clk
//   edge it samples the signed operands A and B. It then raises exactly one of
//   three flags: greater, equal or less. The compare is done with a WIDTH+1-bit
//   sign-extended subtraction, so it cannot overflow. Every output is a flop,
//   so there is no combinational path from the inputs to the outputs.
//
// Optional feature:
//   SIGNED_COMPARATOR_DIFF_EN - when defined, the block adds the registered
//   WIDTH+1-bit signed difference output 'diff' (A - B). The flags come from
//   the same subtractor in both builds, so flag behaviour does not change.
//
// Parameters:
//   WIDTH        operand width in bits, legal range 2..32 (default 4)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset; clears every output
//   A, B         signed operands, WIDTH bits each
//   A_greater_B  registered, 1 when A > B (signed)
//   A_equal_B    registered, 1 when A == B
//   A_less_B     registered, 1 when A < B (signed)
//   diff         registered A - B, WIDTH+1 bits (only with the DIFF_EN build)
// -----------------------------------------------------------------------------
module signed_comparator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             A_greater_B,
    output logic             A_equal_B,
    output logic             A_less_B
`ifdef SIGNED_COMPARATOR_DIFF_EN
    ,
    output logic [WIDTH:0]   diff
`endif
);

    // Widen a two's-complement operand by one bit, replicating the sign bit.
    function automatic logic [WIDTH:0] sign_extend(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

    logic [WIDTH:0] diff_d;
    logic           gt_d;
    logic           eq_d;
    logic           lt_d;

    logic           gt_q;
    logic           eq_q;
    logic           lt_q;

    // Next-state flags from one overflow-free subtractor. The result spans
    // -(2^WIDTH - 1) .. 2^WIDTH - 1, so it always fits in WIDTH+1 signed bits.
    // That makes its MSB the true "less than" indication. A zero difference
    // happens exactly when the operands are bitwise equal.
    always_comb begin
        diff_d = sign_extend(A) - sign_extend(B);
        eq_d   = (diff_d == {(WIDTH+1){1'b0}});
        lt_d   = diff_d[WIDTH];
        gt_d   = ~eq_d & ~lt_d;
    end

    // Flag registers; asynchronous reset clears the flags without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_q <= 1'b0;
            eq_q <= 1'b0;
            lt_q <= 1'b0;
        end else begin
            gt_q <= gt_d;
            eq_q <= eq_d;
            lt_q <= lt_d;
        end
    end

    assign A_greater_B = gt_q;
    assign A_equal_B   = eq_q;
    assign A_less_B    = lt_q;

`ifdef SIGNED_COMPARATOR_DIFF_EN
    logic [WIDTH:0] diff_q;

    // Difference register; same latency and reset behaviour as the flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q <= {(WIDTH+1){1'b0}};
        end else begin
            diff_q <= diff_d;
        end
    end

    assign diff = diff_q;
`endif

endmodule

// File: tb/tb_signed_comparator.sv
// -----------------------------------------------------------------------------
// tb_signed_comparator
//
// Self-checking bench for signed_comparator with WIDTH=4. Operands are turned
// into plain integers, and each expected flag comes from ordinary integer
// ordering. Every result is checked one cycle after its operands are applied.
// -----------------------------------------------------------------------------
module tb_signed_comparator;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         A_greater_B;
    logic         A_equal_B;
    logic         A_less_B;
`ifdef SIGNED_COMPARATOR_DIFF_EN
    logic [W:0]   diff;
`endif

    int checks   = 0;
    int failures = 0;

    signed_comparator #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .A           (A),
        .B           (B),
        .A_greater_B (A_greater_B),
        .A_equal_B   (A_equal_B),
        .A_less_B    (A_less_B)
`ifdef SIGNED_COMPARATOR_DIFF_EN
        ,
        .diff        (diff)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the ordering of two integers, as {gt, eq, lt}.
    function automatic logic [2:0] ref_flags(input int a, input int b);
        if (a > b)       return 3'b100;
        else if (a == b) return 3'b010;
        else             return 3'b001;
    endfunction

    // Compare the registered outputs against the model for operands (a, b).
    task automatic check_result(input string tag, input int a, input int b);
        logic [2:0] obs;
        logic [2:0] exp;
        obs = {A_greater_B, A_equal_B, A_less_B};
        exp = ref_flags(a, b);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s A=%0d B=%0d flags(gt,eq,lt) observed=%b expected=%b",
                   tag, a, b, obs, exp);
        end
`ifdef SIGNED_COMPARATOR_DIFF_EN
        begin
            logic [W:0] dexp;
            dexp = (W+1)'(a - b);
            checks++;
            assert (diff === dexp) else begin
                failures++;
                $error("FAIL %s_diff A=%0d B=%0d observed=%0d expected=%0d",
                       tag, a, b, $signed(diff), a - b);
            end
        end
`endif
    endtask

    // Every output must read as its reset value.
    task automatic check_zero(input string tag);
        logic [2:0] obs;
        obs = {A_greater_B, A_equal_B, A_less_B};
        checks++;
        assert (obs === 3'b000) else begin
            failures++;
            $error("FAIL %s flags observed=%b expected=000", tag, obs);
        end
`ifdef SIGNED_COMPARATOR_DIFF_EN
        checks++;
        assert (diff === {(W+1){1'b0}}) else begin
            failures++;
            $error("FAIL %s_diff observed=%b expected=0", tag, diff);
        end
`endif
    endtask

    // Drive one signed pair, clock it in and check the registered result.
    task automatic step(input string tag, input int a, input int b);
        A = W'(a);
        B = W'(b);
        @(posedge clk);
        #1;
        check_result(tag, a, b);
    endtask

    initial begin
        int ra;
        int rb;

        // Reset held with live operands: no edge may load a result.
        rst = 1'b1;
        A   = W'(5);
        B   = W'(3);
        #1;
        check_zero("rst_initial");
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_held");

        // Release between edges: flags stay 0 until the next rising edge.
        rst = 1'b0;
        #2;
        check_zero("rst_release");

        // First edge after release produces a valid result.
        step("first_gt", 5, 3);

        // Asynchronous reset mid-cycle drops the flags without a clock.
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        check_zero("rst_async_hold");
        rst = 1'b0;

        // Directed sequence, one pair per cycle.
        step("dir_5_3",   5,  3);
        step("dir_2_2",   2,  2);
        step("dir_m1_1", -1,  1);
        step("dir_m4_m3", -4, -3);
        step("dir_m7_m7", -7, -7);
        step("dir_0_0",   0,  0);
        step("dir_7_m1",  7, -1);

        // Extremes, where a plain WIDTH-bit subtraction would overflow.
        step("ext_7_m8",   7, -8);
        step("ext_m8_7",  -8,  7);
        step("ext_m8_m8", -8, -8);

        // Latency: consecutive operand changes with no skipped or stale result.
        step("lat_1_0", 1, 0);
        step("lat_0_1", 0, 1);
        step("lat_1_1", 1, 1);

        // Exhaustive, back-to-back.
        for (int a = -(1 << (W-1)); a < (1 << (W-1)); a++) begin
            for (int b = -(1 << (W-1)); b < (1 << (W-1)); b++) begin
                step("exh", a, b);
            end
        end

        // Random pairs.
        for (int i = 0; i < 200; i++) begin
            ra = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
            rb = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
            step("rand", ra, rb);
        end

        // Reset at the end also clears a held result.
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signed_comparator.md
# signed_comparator

Registered two's-complement magnitude comparator. Each clock cycle it samples two signed operands and raises exactly one of three flags: greater, equal or less. It is a leaf datapath block used wherever signed threshold or ordering decisions are needed, and its outputs are registered so they can drive downstream control logic directly.

## Interface

Parameters:
- WIDTH, default 4: operand width in bits; both operands are two's complement; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset; asserting it immediately forces all outputs to their reset values, and release is sampled on clk.
- A  input  WIDTH  signed operand A.
- B  input  WIDTH  signed operand B.
- A_greater_B  output  1  registered; 1 when A > B (signed).
- A_equal_B  output  1  registered; 1 when A == B.
- A_less_B  output  1  registered; 1 when A < B (signed).
- diff  output  WIDTH+1  registered signed A − B; present only when SIGNED_COMPARATOR_DIFF_EN is defined.

## Operation

- A and B are interpreted as two's complement. The MSB is the sign bit, and the range is −2^(WIDTH−1) .. 2^(WIDTH−1)−1.
- The comparison uses WIDTH+1-bit sign-extended subtraction, or an equivalent signed compare, so it never overflows. For example, with WIDTH=4, 7 vs −8 gives greater and −8 vs 7 gives less.
- Flag computation per cycle:
  - eq = (A == B), a bitwise comparison.
  - lt = signed(A) < signed(B).
  - gt = !eq && !lt.
- Flag invariants:
  - Outside reset, exactly one flag is 1 (one-hot).
  - In reset, all flags are 0.
- Operand bits that are X or Z have undefined results; the verification bench does not drive them.
- No enable and no handshake: the block samples inputs on every rising clk edge.
- In reset, diff = 0 when it is present.

## Timing

- Latency is 1 cycle. Inputs present before rising edge N appear on the outputs after edge N and hold until edge N+1.
- Throughput is one comparison per cycle. Back-to-back operand changes each produce a result one cycle later, with no bubbles.
- Reset assertion is asynchronous. It clears A_greater_B, A_equal_B, A_less_B and diff within the same cycle, with no clock needed.
- Reset asserted between edges discards the result in flight.
- After rst deasserts, the first rising edge registers a valid result. Before that edge, all flags read 0.
- Outputs are glitch-free flops; there are no combinational paths from inputs to outputs.

## Configuration

- SIGNED_COMPARATOR_DIFF_EN:
  - When defined, the block adds the diff output port: a registered WIDTH+1-bit signed value equal to A − B.
  - diff has the same latency as the flags and a reset value of 0.
  - The flags are derived from the same subtractor, so diff's sign equals A_less_B and diff == 0 equals A_equal_B.
- When undefined, the diff port and its register do not exist. Flag behaviour is identical in both builds.

## Test plan

All scenarios use WIDTH=4.

- Reset: hold rst=1 with A=5, B=3, then toggle clk → all flags 0 (and diff=0). Assert rst mid-cycle while A_greater_B=1 → the flags drop immediately, with no clock edge.
- Directed sequence, one pair per cycle, each result checked one cycle later:
  - (5,3) → gt
  - (2,2) → eq
  - (−1,1) → lt
  - (−4,−3) → lt
  - (−7,−7) → eq
  - (0,0) → eq
  - (7,−1) → gt
- Extremes: (7,−8) → gt; (−8,7) → lt; (−8,−8) → eq. With DIFF_EN: diff = +15, −15, 0.
- Exhaustive: all 256 (A,B) pairs streamed back-to-back → each result matches a signed reference model one cycle later, and the flags are one-hot every post-reset cycle.
- Latency: change the operands on consecutive cycles from (1,0) to (0,1) to (1,1) → flag outputs gt, lt, eq on successive cycles, with no stale or skipped values.
- Build both with and without SIGNED_COMPARATOR_DIFF_EN → identical flag traces for the same stimulus.
